control_sequencer: RTL

//  Microcoded control unit for the 8-bit bus computer. Steps each instruction through T-states and

---
 rtl/control_sequencer_if.sv | 22 ++
 rtl/control_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Bus bundle between the control sequencer and the rest of the 8-bit bus computer.
// The sequencer (slave side) consumes opcode/flags and produces the control word, step and halted.
interface control_sequencer_if #(
    parameter int STEP_W = 3
);
    logic [3:0]        opcode;
    logic              carry;
    logic              zero;
    logic [15:0]       ctrl;
    logic [STEP_W-1:0] step;
    logic              halted;

    modport master (
        output opcode, carry, zero,
        input  ctrl, step, halted
    );

    modport slave (
        input  opcode, carry, zero,
        output ctrl, step, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer: steps each instruction and decodes the 16-bit bus control word.
// Optional macro SEQ_EARLY_END_EN ends an instruction right after its last non-empty step.
module control_sequencer #(
    parameter int NUM_STEPS = 6,
    parameter int STEP_W    = 3
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.slave  bus
);
    localparam logic [15:0] HLT      = 16'h0001;
    localparam logic [15:0] MAR_IN   = 16'h0002;
    localparam logic [15:0] RAM_IN   = 16'h0004;
    localparam logic [15:0] RAM_OUT  = 16'h0008;
    localparam logic [15:0] IR_IN    = 16'h0010;
    localparam logic [15:0] IR_OUT   = 16'h0020;
    localparam logic [15:0] A_IN     = 16'h0040;
    localparam logic [15:0] A_OUT    = 16'h0080;
    localparam logic [15:0] ALU_OUT  = 16'h0100;
    localparam logic [15:0] SUB      = 16'h0200;
    localparam logic [15:0] B_IN     = 16'h0400;
    localparam logic [15:0] OUT_IN   = 16'h0800;
    localparam logic [15:0] PC_INC   = 16'h1000;
    localparam logic [15:0] PC_OUT   = 16'h2000;
    localparam logic [15:0] PC_JUMP  = 16'h4000;
    localparam logic [15:0] FLAGS_IN = 16'h8000;

    localparam logic [3:0]        OP_HLT    = 4'b1111;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_EXEC = STEP_W'(2);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;

    function automatic logic [15:0] decode(input logic [STEP_W-1:0] s, input logic [3:0] op,
                                           input logic c, input logic z);
        logic [15:0] w;
        w = '0;
        case (int'(s))
            0: w = PC_OUT | MAR_IN;
            1: w = RAM_OUT | IR_IN | PC_INC;
            2: begin
                case (op)
                    4'b0001, 4'b0010, 4'b0011, 4'b0100: w = IR_OUT | MAR_IN;
                    4'b0101: w = IR_OUT | A_IN;
                    4'b0110: w = IR_OUT | PC_JUMP;
                    4'b0111: w = c ? (IR_OUT | PC_JUMP) : 16'h0000;
                    4'b1000: w = z ? (IR_OUT | PC_JUMP) : 16'h0000;
                    4'b1110: w = A_OUT | OUT_IN;
                    4'b1111: w = HLT;
                    default: w = '0;
                endcase
            end
            3: begin
                case (op)
                    4'b0001: w = RAM_OUT | A_IN;
                    4'b0010, 4'b0011: w = RAM_OUT | B_IN;
                    4'b0100: w = A_OUT | RAM_IN;
                    default: w = '0;
                endcase
            end
            4: begin
                case (op)
                    4'b0010: w = ALU_OUT | A_IN | FLAGS_IN;
                    4'b0011: w = ALU_OUT | A_IN | FLAGS_IN | SUB;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    logic        end_now;
    logic [15:0] next_decode;

    always_comb begin
        next_decode = decode(step_q + STEP_W'(1), bus.opcode, bus.carry, bus.zero);
`ifdef SEQ_EARLY_END_EN
        // Past fetch, an all-zero next step means the instruction has nothing left to do.
        end_now = (step_q == STEP_LAST) || ((step_q >= STEP_EXEC) && (next_decode == 16'h0000));
`else
        end_now = (step_q == STEP_LAST);
`endif
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (clr) begin
            state_d = ST_RUN;
            step_d  = '0;
        end else if (state_q == ST_HALT) begin
            step_d  = step_q;
        end else if ((step_q == STEP_EXEC) && (bus.opcode == OP_HLT)) begin
            state_d = ST_HALT;
            step_d  = step_q;
        end else if (end_now) begin
            step_d  = '0;
        end else begin
            step_d  = step_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RUN;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Halted output mirrors the FSM state; once halted the word is pinned to HLT.
    always_comb begin
        if (clr) begin
            bus.ctrl = 16'h0000;
        end else if (state_q == ST_HALT) begin
            bus.ctrl = HLT;
        end else begin
            bus.ctrl = decode(step_q, bus.opcode, bus.carry, bus.zero);
        end
        bus.step   = step_q;
        bus.halted = (state_q == ST_HALT);
    end
endmodule
